// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
// Parametrised Moore serial pattern detector. Shifts in one bit per enabled
// clock, compares the newest SEQ_LEN bits against a pattern and raises a
// registered one-cycle det pulse on a match. Matches bump a saturating counter.
// Overlapping or non-overlapping detection is selected at run time.
//
// Optional feature: define RUNTIME_PATTERN_EN to add a loadable pattern
// register (pat_in/pat_ld). Without it the pattern is the constant PATTERN.
//
// Ports
//   clk      in   1        clock, rising edge
//   rst      in   1        asynchronous active-high reset
//   en       in   1        bit-valid qualifier, inp sampled only when en=1
//   inp      in   1        serial data bit
//   overlap  in   1        1 = overlapping detection, 0 = non-overlapping
//   cnt_clr  in   1        synchronous clear of det_cnt (wins over a match)
//   pat_in   in   SEQ_LEN  new pattern (RUNTIME_PATTERN_EN only)
//   pat_ld   in   1        load pat_in, flush history (RUNTIME_PATTERN_EN only)
//   det      out  1        registered detect pulse
//   det_cnt  out  CNT_W    saturating count of detections
// -----------------------------------------------------------------------------
module seq_det_param #(
   parameter int unsigned          SEQ_LEN = 3,
   parameter logic [SEQ_LEN-1:0]   PATTERN = 3'b001,
   parameter int unsigned          CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               inp,
   input  logic               overlap,
   input  logic               cnt_clr,
`ifdef RUNTIME_PATTERN_EN
   input  logic [SEQ_LEN-1:0] pat_in,
   input  logic               pat_ld,
`endif
   output logic               det,
   output logic [CNT_W-1:0]   det_cnt
);

   localparam int unsigned       FillW   = $clog2(SEQ_LEN + 1);
   localparam logic [FillW-1:0]  FillMax = FillW'(SEQ_LEN);

   // Only the newest SEQ_LEN-1 bits need storing: the comparison window is
   // always formed from them plus the incoming bit, so the oldest stored bit
   // would never be read.
   logic [SEQ_LEN-2:0] hist_q, hist_d;
   logic [FillW-1:0]   fill_q, fill_d;
   logic               det_q, det_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [SEQ_LEN-1:0] pattern;
   logic [SEQ_LEN-1:0] hist_n;
   logic [FillW-1:0]   fill_n;
   logic               sample;
   logic               match;

`ifdef RUNTIME_PATTERN_EN
   logic [SEQ_LEN-1:0] pat_q, pat_d;

   assign pattern = pat_q;
   // A load owns the cycle: the bit on inp is dropped.
   assign sample  = en & ~pat_ld;
`else
   assign pattern = PATTERN;
   assign sample  = en;
`endif

   assign hist_n = {hist_q, inp};
   assign fill_n = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
   // fill guards against matching on the zeros left behind by reset.
   assign match  = sample && (fill_n == FillMax) && (hist_n == pattern);

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      det_d  = 1'b0;
      cnt_d  = cnt_q;

      if (sample) begin
         hist_d = hist_n[SEQ_LEN-2:0];
         // Non-overlap: a completed match consumes its bits.
         fill_d = (match && !overlap) ? '0 : fill_n;
         det_d  = match;
      end

      if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end

`ifdef RUNTIME_PATTERN_EN
      pat_d = pat_q;
      if (pat_ld) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
         det_d  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
         cnt_q  <= '0;
`ifdef RUNTIME_PATTERN_EN
         pat_q  <= PATTERN;
`endif
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
`ifdef RUNTIME_PATTERN_EN
         pat_q  <= pat_d;
`endif
      end
   end

   assign det     = det_q;
   assign det_cnt = cnt_q;

endmodule
